// File: rtl/chroma_bg_reader_if.sv
// Memory read port between the background reader and pixel memory.
// The reader drives address/request; memory returns stall, valid and RGB565 data.
interface chroma_bg_reader_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic              oMEM_RD;
  logic              iMEM_WAIT;
  logic              iMEM_RDVALID;
  logic [15:0]       iMEM_DATA;

  modport master (
    output oMEM_ADDR, oMEM_RD,
    input  iMEM_WAIT, iMEM_RDVALID, iMEM_DATA
  );

  modport slave (
    input  oMEM_ADDR, oMEM_RD,
    output iMEM_WAIT, iMEM_RDVALID, iMEM_DATA
  );
endinterface

// File: rtl/chroma_bg_reader.sv
// Background-image source for the chroma-key mixer: prefetches an RGB565 frame into a
// FIFO and delivers one 10-bit-per-channel pixel per VGA request, in raster order.
//
// state | meaning
// IDLE  | no frame being fetched
// FETCH | issuing reads until the whole frame has been requested
// DRAIN | all reads issued, waiting for FIFO to empty and returns to retire
module chroma_bg_reader #(
  parameter int              H_ACT      = 640,
  parameter int              V_ACT      = 480,
  parameter int              ADDR_W     = 19,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              FIFO_DEPTH = 16,
  parameter logic [9:0]      FILL_COLOR = 10'd2
) (
  input  logic                       iCLK27,
  input  logic                       iRST,
  input  logic                       iEN,
  input  logic                       iFRAME_START,
  input  logic                       iVGA_REQ,
  chroma_bg_reader_if.master         mem,
  output logic [9:0]                 oIM_R,
  output logic [9:0]                 oIM_G,
  output logic [9:0]                 oIM_B,
  output logic                       oIM_VALID,
  output logic [15:0]                oUNDERFLOW
);
  localparam int TOTAL = H_ACT * V_ACT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [OCC_W-1:0]  out_q, out_d, drop_q, drop_d, count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic              stall_q;
  logic [9:0]        r_q, g_q, b_q;
  logic              valid_q;
  logic [15:0]       und_q;

  logic              restart, issue_ok, rd, accept, retire, push, pop, fifo_empty;
  logic [OCC_W:0]    occupancy;
  logic [15:0]       head;

  assign restart   = iFRAME_START & iEN;
  assign occupancy = {1'b0, count_q} + {1'b0, out_q};

  always_ff @(posedge iCLK27) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      FETCH:   if (issued_q == CNT_W'(TOTAL)) state_d = DRAIN;
      DRAIN:   if (count_q == '0 && out_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restart) state_d = FETCH;
  end

  always_comb begin
    issue_ok = (state_q == FETCH) && iEN && !restart &&
               (occupancy < (OCC_W+1)'(FIFO_DEPTH)) && (issued_q < CNT_W'(TOTAL));
  end

  // A stalled request stays up regardless of enable so memory sees a stable command.
  assign rd         = issue_ok | stall_q;
  assign accept     = rd & ~mem.iMEM_WAIT;
  assign retire     = mem.iMEM_RDVALID;
  assign fifo_empty = (count_q == '0) || restart;
  assign push       = retire && (drop_q == '0) && !restart;
  assign pop        = iVGA_REQ && iEN && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    out_d    = out_q + OCC_W'(accept) - OCC_W'(retire);
    addr_d   = addr_q;
    issued_d = issued_q;
    drop_d   = drop_q;
    count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
    if (accept) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + CNT_W'(1);
    end
    if (retire && drop_q != '0) drop_d = drop_q - OCC_W'(1);
    // Everything still in flight at a restart belongs to the old frame.
    if (restart) begin
      addr_d   = BASE_ADDR;
      issued_d = '0;
      drop_d   = out_d;
      count_d  = '0;
    end
  end

  always_ff @(posedge iCLK27) begin
    if (iRST) begin
      addr_q   <= BASE_ADDR;
      issued_q <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      issued_q <= issued_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      stall_q  <= rd & mem.iMEM_WAIT & ~restart;
      if (restart) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK27) begin
    if (push) fifo_q[wr_ptr_q] <= mem.iMEM_DATA;
  end

  always_ff @(posedge iCLK27) begin
    if (iRST) begin
      r_q     <= FILL_COLOR;
      g_q     <= FILL_COLOR;
      b_q     <= FILL_COLOR;
      valid_q <= 1'b0;
      und_q   <= '0;
    end else if (!iEN) begin
      r_q     <= FILL_COLOR;
      g_q     <= FILL_COLOR;
      b_q     <= FILL_COLOR;
      valid_q <= 1'b0;
    end else if (iVGA_REQ) begin
      if (pop) begin
        r_q     <= {head[15:11], head[15:11]};
        g_q     <= {head[10:5], head[10:7]};
        b_q     <= {head[4:0], head[4:0]};
        valid_q <= 1'b1;
      end else begin
        r_q     <= FILL_COLOR;
        g_q     <= FILL_COLOR;
        b_q     <= FILL_COLOR;
        valid_q <= 1'b0;
        if (und_q != 16'hFFFF) und_q <= und_q + 16'd1;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign mem.oMEM_ADDR = addr_q;
  assign mem.oMEM_RD   = rd;
  assign oIM_R         = r_q;
  assign oIM_G         = g_q;
  assign oIM_B         = b_q;
  assign oIM_VALID     = valid_q;
  assign oUNDERFLOW    = und_q;
endmodule
